// File: rtl/code_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl_if
// Digit handshake between the keypad digit source (master) and the code lock
// entry controller (slave). A digit transfers on a rising clock edge when
// in_valid and in_ready are both high.
//   in_valid  master -> slave   digit present on in_digit
//   in_digit  master -> slave   digit value, DIGIT_W bits
//   in_ready  slave  -> master  controller can accept a digit
// DIGIT_W must match the DIGIT_W of the connected code_lock_ctrl.
// -----------------------------------------------------------------------------
interface code_lock_ctrl_if #(
  parameter int DIGIT_W = 3
) ();
  logic               in_valid;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_ready;

  modport master (
    output in_valid,
    output in_digit,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_digit,
    output in_ready
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl
// Entry controller for the digit-code lock. Collects CODE_LEN digits over the
// dig handshake, compares them with CODE (first digit in the most significant
// DIGIT_W bits), and issues one-cycle unlock/fail pulses. MAX_FAIL consecutive
// failures put the controller into a LOCKOUT of exactly LOCK_CYCLES cycles,
// during which offered digits are dropped.
//
// Ports
//   clk       rising-edge clock
//   clear     asynchronous reset, active-high
//   dig       digit handshake (slave side): in_valid, in_digit, in_ready
//   unlock    1-cycle pulse: entered code matched
//   fail      1-cycle pulse: entered code mismatched
//   locked    high for the whole lockout (decoded from state)
//   fail_cnt  consecutive failure count, never above MAX_FAIL
//   state     IDLE=00 ENTRY=01 VERIFY=10 LOCKOUT=11
//   timeout   1-cycle pulse: entry aborted after TIMEOUT idle cycles
//
// Build option
//   ENTRY_TIMEOUT_EN  when defined, an idle counter runs in ENTRY and aborts
//                     a partial entry after TIMEOUT cycles without a digit
//                     (adds the TIMEOUT parameter). When undefined, ENTRY
//                     waits indefinitely and timeout is tied low.
// -----------------------------------------------------------------------------
module code_lock_ctrl #(
  parameter int                               DIGIT_W     = 3,
  parameter int                               CODE_LEN    = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0]      CODE        = 12'b000111000011,
  parameter int                               MAX_FAIL    = 3,
  parameter int                               LOCK_CYCLES = 16
`ifdef ENTRY_TIMEOUT_EN
  ,
  parameter int                               TIMEOUT     = 32
`endif
) (
  input  logic                              clk,
  input  logic                              clear,
  code_lock_ctrl_if.slave                   dig,
  output logic                              unlock,
  output logic                              fail,
  output logic                              locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
  output logic [1:0]                        state,
  output logic                              timeout
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int FC_W   = $clog2(MAX_FAIL + 1);
  localparam int LC_W   = $clog2(LOCK_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_LAST = FC_W'(MAX_FAIL - 1);
  localparam logic [LC_W-1:0]  LOCK_LAST = LC_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ENTRY   = 2'b01,
    S_VERIFY  = 2'b10,
    S_LOCKOUT = 2'b11
  } state_t;

  state_t            state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [CODE_W-1:0] code_q,     code_d;
  logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              unlock_q,   unlock_d;
  logic              fail_q,     fail_d;
  logic              accept;

`ifdef ENTRY_TIMEOUT_EN
  localparam int             IW        = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`endif

  assign dig.in_ready = (state_q == S_IDLE) || (state_q == S_ENTRY);
  assign accept       = dig.in_valid && dig.in_ready;

  // Next-state and datapath decisions.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    code_d     = code_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    idle_d     = idle_q;
    timeout_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          code_d  = CODE_W'(dig.in_digit);
          idx_d   = IDX_W'(1);
          state_d = (CODE_LEN == 1) ? S_VERIFY : S_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end

      S_ENTRY: begin
        if (accept) begin
          // Shift left so the first digit ends up in the top DIGIT_W bits.
          code_d = (code_q << DIGIT_W) | CODE_W'(dig.in_digit);
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_VERIFY;
          end
`ifdef ENTRY_TIMEOUT_EN
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          // Abandoned entry: drop the partial code, keep the failure count.
          state_d   = S_IDLE;
          idx_d     = '0;
          code_d    = '0;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
`endif
        end
      end

      S_VERIFY: begin
        idx_d  = '0;
        code_d = '0;
        if (code_q == CODE) begin
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == FAIL_LAST) begin
            lock_cnt_d = '0;
            state_d    = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d = '0;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      code_q     <= '0;
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= idle_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign unlock   = unlock_q;
  assign fail     = fail_q;
  assign locked   = (state_q == S_LOCKOUT);
  assign fail_cnt = fail_cnt_q;
  assign state    = state_q;
`ifdef ENTRY_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_code_lock_ctrl
// Directed scenarios for the code lock controller followed by a randomized run
// checked cycle by cycle against a queue-based behavioural model of the lock.
// Outputs are sampled 1 time unit after the rising edge; inputs are changed at
// the same point, so each digit is taken on the following edge.
// The observation vector is {state, in_ready, locked, unlock, fail, timeout,
// fail_cnt}, printed as a 9-bit binary value.
// -----------------------------------------------------------------------------
module tb_code_lock_ctrl;

  localparam int CODE_LEN    = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int TIMEOUT     = 32;

  logic       clk   = 1'b0;
  logic       clear = 1'b0;
  logic       unlock;
  logic       fail;
  logic       locked;
  logic [1:0] fail_cnt;
  logic [1:0] state;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  int code_digits[CODE_LEN] = '{0, 7, 0, 3};

  code_lock_ctrl_if #(.DIGIT_W(3)) dig ();

  code_lock_ctrl dut (
    .clk      (clk),
    .clear    (clear),
    .dig      (dig),
    .unlock   (unlock),
    .fail     (fail),
    .locked   (locked),
    .fail_cnt (fail_cnt),
    .state    (state),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Observation helpers
  // ---------------------------------------------------------------------------
  function automatic logic [8:0] obs();
    return {state, dig.in_ready, locked, unlock, fail, timeout, fail_cnt};
  endfunction

  function automatic logic [8:0] exp_v(input int st, input int rdy, input int lck,
                                       input int unl, input int fl, input int to,
                                       input int fc);
    return {2'(st), 1'(rdy), 1'(lck), 1'(unl), 1'(fl), 1'(to), 2'(fc)};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons)
  // ---------------------------------------------------------------------------
  task automatic send(input int d);
    dig.in_valid = 1'b1;
    dig.in_digit = 3'(d);
    @(posedge clk);
    #1;
    dig.in_valid = 1'b0;
  endtask

  task automatic send_code(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic idle(input int n);
    dig.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model: digits collected in a queue, lockout as a
  // countdown of remaining cycles.
  // ---------------------------------------------------------------------------
  int m_q[$];
  bit m_verify;
  int m_lock_left;
  int m_fails;
  bit m_unlock, m_fail, m_timeout;
  int m_idle;

  task automatic model_reset();
    m_q.delete();
    m_verify    = 1'b0;
    m_lock_left = 0;
    m_fails     = 0;
    m_unlock    = 1'b0;
    m_fail      = 1'b0;
    m_timeout   = 1'b0;
    m_idle      = 0;
  endtask

  function automatic logic [8:0] model_obs();
    int st;
    if (m_lock_left > 0)    st = 3;
    else if (m_verify)      st = 2;
    else if (m_q.size() > 0) st = 1;
    else                    st = 0;
    return exp_v(st, int'(!m_verify && m_lock_left == 0), int'(m_lock_left > 0),
                 int'(m_unlock), int'(m_fail), int'(m_timeout), m_fails);
  endfunction

  task automatic model_step(input bit v, input int d);
    bit match;
    m_unlock  = 1'b0;
    m_fail    = 1'b0;
    m_timeout = 1'b0;
    if (m_verify) begin
      match = 1'b1;
      for (int i = 0; i < CODE_LEN; i++)
        if (m_q[i] != code_digits[i]) match = 1'b0;
      if (match) begin
        m_unlock = 1'b1;
        m_fails  = 0;
      end else begin
        m_fail  = 1'b1;
        m_fails = m_fails + 1;
        if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
      end
      m_q.delete();
      m_verify = 1'b0;
    end else if (m_lock_left > 0) begin
      m_lock_left = m_lock_left - 1;
      if (m_lock_left == 0) m_fails = 0;
    end else if (v) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == CODE_LEN) m_verify = 1'b1;
    end else if (m_q.size() > 0) begin
`ifdef ENTRY_TIMEOUT_EN
      m_idle = m_idle + 1;
      if (m_idle == TIMEOUT) begin
        m_q.delete();
        m_timeout = 1'b1;
        m_idle    = 0;
      end
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [8:0] want;
    dig.in_valid = 1'b0;
    dig.in_digit = '0;
    #1 clear = 1'b1;
    #1;
    want = exp_v(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs(), want);
    end
    dig.in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL reset_holds_idle: got %b want %b", obs(), want);
    end
    #2 clear = 1'b0;
    dig.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_correct_code();
    logic [8:0] want;
    send_code(0, 7, 0, 3);
    want = exp_v(2, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL correct_verify: got %b want %b", obs(), want);
    end
    idle(1);
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL correct_unlock: got %b want %b", obs(), want);
    end
    idle(1);
    want = exp_v(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL correct_pulse_end: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_wrong_code();
    logic [8:0] want;
    send_code(6, 0, 7, 0);
    idle(1);
    want = exp_v(0, 1, 0, 0, 1, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL wrong_fail: got %b want %b", obs(), want);
    end
    idle(1);
    want = exp_v(0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL wrong_pulse_end: got %b want %b", obs(), want);
    end
  endtask

  // Entered with fail_cnt=1; two more failures start the lockout.
  task automatic test_lockout();
    logic [8:0] want;
    int locked_cycles = 0;
    int bad_during    = 0;
    int n             = 0;
    send_code(1, 1, 1, 1);
    idle(1);
    want = exp_v(0, 1, 0, 0, 1, 0, 2);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL lockout_second_fail: got %b want %b", obs(), want);
    end
    send_code(7, 0, 3, 0);
    idle(1);
    want = exp_v(3, 0, 1, 0, 1, 0, 3);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL lockout_enter: got %b want %b", obs(), want);
    end
    // Keep offering the right code; every digit must be dropped.
    while (locked === 1'b1 && n < 100) begin
      locked_cycles++;
      if (unlock !== 1'b0 || fail_cnt !== 2'd3 || dig.in_ready !== 1'b0 || state !== 2'd3)
        bad_during++;
      dig.in_valid = 1'b1;
      dig.in_digit = 3'(code_digits[n % CODE_LEN]);
      @(posedge clk);
      #1;
      n++;
    end
    dig.in_valid = 1'b0;
    checks++;
    if (locked_cycles !== LOCK_CYCLES) begin
      errors++;
      $display("FAIL lockout_length: got %0d cycles want %0d", locked_cycles, LOCK_CYCLES);
    end
    checks++;
    if (bad_during !== 0) begin
      errors++;
      $display("FAIL lockout_outputs: got %0d bad cycles want 0", bad_during);
    end
    want = exp_v(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL lockout_exit: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_recover();
    logic [8:0] want;
    send_code(0, 7, 0, 2);
    idle(1);
    want = exp_v(0, 1, 0, 0, 1, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL recover_fail: got %b want %b", obs(), want);
    end
    send_code(0, 7, 0, 3);
    idle(1);
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL recover_unlock: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_async_clear();
    logic [8:0] want;
    send_code(5, 5, 5, 5);
    idle(1);
    send(0);
    send(7);
    want = exp_v(1, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_pre_entry: got %b want %b", obs(), want);
    end
    #2 clear = 1'b1;
    #1;
    want = exp_v(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_mid_entry: got %b want %b", obs(), want);
    end
    #2 clear = 1'b0;
    @(posedge clk);
    #1;
    // Pending unlock must be discarded when clear lands in VERIFY.
    send_code(0, 7, 0, 3);
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_mid_verify: got %b want %b", obs(), want);
    end
    send_code(0, 7, 0, 3);
    idle(1);
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL clear_then_unlock: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_timeout();
    logic [8:0] want;
    send_code(2, 2, 2, 2);
    idle(1);
    send(0);
    send(7);
    idle(TIMEOUT - 1);
    want = exp_v(1, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL timeout_before: got %b want %b", obs(), want);
    end
    idle(1);
`ifdef ENTRY_TIMEOUT_EN
    want = exp_v(0, 1, 0, 0, 0, 1, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL timeout_pulse: got %b want %b", obs(), want);
    end
    idle(1);
    want = exp_v(0, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL timeout_pulse_end: got %b want %b", obs(), want);
    end
    send_code(0, 7, 0, 3);
`else
    want = exp_v(1, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL timeout_waits: got %b want %b", obs(), want);
    end
    send(0);
    send(3);
`endif
    idle(1);
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL timeout_then_unlock: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] want;
    send_code(0, 7, 0, 3);
    // Digit offered during VERIFY must be dropped.
    dig.in_valid = 1'b1;
    dig.in_digit = 3'd5;
    @(posedge clk);
    #1;
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL b2b_drop_in_verify: got %b want %b", obs(), want);
    end
    send_code(0, 7, 0, 3);
    want = exp_v(2, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL b2b_second_verify: got %b want %b", obs(), want);
    end
    idle(1);
    want = exp_v(0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL b2b_second_unlock: got %b want %b", obs(), want);
    end
    send_code(1, 1, 1, 1);
    idle(1);
    want = exp_v(0, 1, 0, 0, 1, 0, 1);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL b2b_fail_after_unlock: got %b want %b", obs(), want);
    end
  endtask

  task automatic test_random();
    bit v;
    int d;
    int burst = 0;
    pulse_clear();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (obs() !== model_obs()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b want %b", c, obs(), model_obs());
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 clear = 1'b1;
        #2 clear = 1'b0;
        model_reset();
      end
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = TIMEOUT + 2;
      if (burst > 0) begin
        v = 1'b0;
        burst--;
      end else begin
        v = ($urandom_range(0, 9) < 7);
      end
      if ($urandom_range(0, 1) == 1) d = code_digits[m_q.size() % CODE_LEN];
      else                           d = int'($urandom_range(0, 7));
      dig.in_valid = v;
      dig.in_digit = 3'(d);
      @(posedge clk);
      #1;
      model_step(v, d);
    end
    dig.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_recover();
    test_async_clear();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
